// File: rtl/bkm_pkg.sv
// Shared BKM constants: digit codes, number formats,
// sequencer state encoding and iteration index width.
package bkm_pkg;

  localparam int LOG2N_DEF = 6;

  localparam logic [1:0] DIG_ZERO = 2'b00;
  localparam logic [1:0] DIG_POS  = 2'b01;
  localparam logic [1:0] DIG_NEG  = 2'b11;
  localparam logic [1:0] DIG_ILL  = 2'b10;

  localparam logic [1:0] FMT_FIX = 2'd0;
  localparam logic [1:0] FMT_FLT = 2'd1;
  localparam logic [1:0] FMT_LOG = 2'd2;
  localparam logic [1:0] FMT_CPX = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic dig_illegal(
    input logic [1:0] d
  );
    return d == DIG_ILL;
  endfunction

endpackage

// File: rtl/bkm_step_sequencer_if.sv
// Command/digit inputs and decoder-facing outputs
// of the BKM step sequencer.
interface bkm_step_sequencer_if #(
  parameter int LOG2N = 6
) ();

  logic             enable;
  logic             start;
  logic             mode_in;
  logic [1:0]       format_in;
  logic [LOG2N-1:0] n_last;
  logic             d_valid;
  logic [1:0]       d_x_in;
  logic [1:0]       d_y_in;

  logic             mode;
  logic [1:0]       format;
  logic [LOG2N-1:0] n;
  logic [1:0]       d_x_n;
  logic [1:0]       d_y_n;
  logic             step_valid;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output enable, start, mode_in,
    output format_in, n_last,
    output d_valid, d_x_in, d_y_in,
    input  mode, format, n,
    input  d_x_n, d_y_n, step_valid,
    input  busy, done, err
  );

  modport slave (
    input  enable, start, mode_in,
    input  format_in, n_last,
    input  d_valid, d_x_in, d_y_in,
    output mode, format, n,
    output d_x_n, d_y_n, step_valid,
    output busy, done, err
  );

endinterface

// File: rtl/bkm_digit_check.sv
// Digit legality check: the reserved code 10 is
// flagged and replaced by a zero digit.
module bkm_digit_check
  import bkm_pkg::*;
(
  input  logic [1:0] d_i,
  output logic [1:0] d_o,
  output logic       ill_o
);

  // flag the reserved code and forward zero instead
  always_comb begin
    ill_o = dig_illegal(d_i);
    d_o   = ill_o ? DIG_ZERO : d_i;
  end

endmodule

// File: rtl/bkm_step_sequencer.sv
// BKM iteration sequencer: counts n = 0..n_last and
// issues one registered digit step per accepted pair.
module bkm_step_sequencer
  import bkm_pkg::*;
#(
  parameter int LOG2N = LOG2N_DEF
) (
  input logic clk,
  input logic arst,
  bkm_step_sequencer_if.slave bus
);

  logic [1:0]       dx_san;
  logic [1:0]       dy_san;
  logic             dx_ill;
  logic             dy_ill;

  state_e           state_q;
  logic [LOG2N-1:0] cnt_q;
  logic [LOG2N-1:0] nlast_q;
  logic [LOG2N-1:0] n_q;
  logic             mode_q;
  logic [1:0]       fmt_q;
  logic [1:0]       dx_q;
  logic [1:0]       dy_q;
  logic             step_q;
  logic             done_q;
  logic             busy_q;
  logic             err_q;

  bkm_digit_check u_chk_x (
    .d_i   (bus.d_x_in),
    .d_o   (dx_san),
    .ill_o (dx_ill)
  );

  bkm_digit_check u_chk_y (
    .d_i   (bus.d_y_in),
    .d_o   (dy_san),
    .ill_o (dy_ill)
  );

  // control FSM with registered decoder outputs;
  // busy trails the state so it drops one cycle
  // after the done pulse
  always_ff @(posedge clk) begin
    if (arst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      nlast_q <= '0;
      n_q     <= '0;
      mode_q  <= 1'b0;
      fmt_q   <= 2'b00;
      dx_q    <= DIG_ZERO;
      dy_q    <= DIG_ZERO;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (bus.enable) begin
      step_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= (state_q != S_IDLE);
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            mode_q  <= bus.mode_in;
            fmt_q   <= bus.format_in;
            nlast_q <= bus.n_last;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (bus.d_valid) begin
            n_q    <= cnt_q;
            dx_q   <= dx_san;
            dy_q   <= dy_san;
            step_q <= 1'b1;
            if (dx_ill || dy_ill) begin
              err_q <= 1'b1;
            end
            if (cnt_q == nlast_q) begin
              state_q <= S_DONE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end else begin
      step_q <= 1'b0;
      done_q <= 1'b0;
    end
  end

  assign bus.mode       = mode_q;
  assign bus.format     = fmt_q;
  assign bus.n          = n_q;
  assign bus.d_x_n      = dx_q;
  assign bus.d_y_n      = dy_q;
  assign bus.step_valid = step_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule

// File: doc/bkm_step_sequencer.md
# bkm_step_sequencer

Iteration sequencer placed directly upstream of the BKM LUT decoder. It accepts a start command with operation mode and number format, and counts iterations n = 0 … n_last. For each iteration it accepts one digit pair (d_x, d_y) from the digit-selection stage and presents registered mode/format/n/d_x_n/d_y_n to the decoder with a one-cycle step strobe. It signals busy, done and sticky illegal-digit error.

## Interface
Parameters:
- LOG2N, 6, width of iteration index n (max 2^LOG2N iterations)

Ports:
- clk  in  1  clock; all logic on rising edge
- arst  in  1  reset, synchronous, active-high
- enable  in  1  clock enable; 0 freezes state, counter and data registers
- start  in  1  start request, sampled only in IDLE
- mode_in  in  1  BKM mode (E/L), latched on accepted start
- format_in  in  2  number format, latched on accepted start
- n_last  in  LOG2N  index of last iteration, latched on accepted start
- d_valid  in  1  digit pair valid from digit-selection stage
- d_x_in  in  2  x digit: 00=0, 01=+1, 11=−1, 10 illegal
- d_y_in  in  2  y digit, same encoding
- mode  out  1  registered mode to decoder
- format  out  2  registered format to decoder
- n  out  LOG2N  registered iteration index to decoder
- d_x_n  out  2  registered x digit to decoder
- d_y_n  out  2  registered y digit to decoder
- step_valid  out  1  one-cycle strobe: n/d_x_n/d_y_n hold a new iteration
- busy  out  1  high when state ≠ IDLE
- done  out  1  one-cycle pulse after last iteration issued
- err  out  1  sticky, illegal digit code seen since last start

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE, enable & start: latch mode_in/format_in/n_last, clear cnt and err, go to RUN. start is ignored outside IDLE.
- RUN, enable & d_valid:
  - Register n←cnt, d_x_n←d_x_in, d_y_n←d_y_in and set step_valid=1.
  - If cnt==n_last, go to DONE; else cnt←cnt+1.
- RUN, enable & !d_valid: hold; step_valid=0.
- DONE (enable): done=1 for that cycle, then go to IDLE. n/d outputs keep their last values.
- d_valid is ignored in IDLE and DONE.
- Illegal digit code 10 on an accepted d_valid: the forwarded digit is 00, err←1 (sticky until next accepted start). The step is still issued.
- n_last=0: exactly one step, then DONE.
- The counter never wraps: it stops at n_last ≤ 2^LOG2N−1.
- enable=0: state, cnt and all data outputs hold; step_valid and done are forced 0 on that edge.

## Timing
- Reset (arst high at edge): state IDLE, cnt 0. mode, format, n, d_x_n, d_y_n, step_valid, busy, done and err are all 0.
- arst mid-RUN aborts immediately: no done pulse, outputs return to reset values next edge.
- start accepted at edge t: busy=1 after t. The earliest step_valid is after edge t+1, if d_valid is high in that cycle.
- Digit accept to decoder presentation is 1 cycle: d_valid sampled at edge t gives step_valid/n/d valid after t.
- Back-to-back d_valid gives one step per cycle.
- Last step at edge t: DONE after t, done=1 after t+1, busy=0 after t+2.
- Minimum run for n_last=K with continuous d_valid: start→done = K+3 edges.
- err updates on the same edge as the offending step.

## Structure
- Shared package bkm_pkg holds:
  - LOG2N default
  - digit code constants DIG_ZERO=00, DIG_POS=01, DIG_NEG=11, DIG_ILL=10
  - state encoding IDLE/RUN/DONE
  - format code constants (shared with the LUT decoder)
- One sub-module, bkm_digit_check, instanced twice (x, y): combinational legality check and sanitise (illegal→00, flag).
- Output registers feed the LUT decoder ports mode/format/n/d_x_n/d_y_n directly.

## Test plan
- Reset: arst for 2 cycles mid-RUN (cnt=5) → all outputs 0, state IDLE, no done pulse.
- Nominal: start with n_last=3, mode=1, format=2, continuous d_valid with digits (01,11),(00,01),(11,00),(01,01) → step_valid for 4 consecutive cycles with n=0,1,2,3 and the same digits; done 1 cycle after n=3; busy low next cycle.
- Stall and enable: n_last=2, d_valid gaps of 3 cycles plus enable low for 2 cycles mid-run → exactly 3 strobes, n=0,1,2, no strobe or done while enable=0.
- Illegal digit: d_x_in=10 at n=1 → d_x_n=00, err=1 and held through done; next start clears err.
- Boundary: n_last=0 gives one strobe (n=0) then done. n_last=63 gives 64 strobes, last n=63, no wrap. start during RUN is ignored, latched format unchanged.
